// File: rtl/packet_pkg.sv
// Purpose: shared switch-wide types for the output port arbiters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package packet_pkg;

    localparam int NUM_PORTS = 4;
    localparam int TGT_W     = 4;

    typedef logic [1:0] port_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin picker; first set elig bit scanning upward from ptr+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick #(
    parameter int NUM_IN = 4,
    parameter int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] elig,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_IN-1:0] pick,
    output logic              found
);

    int best;
    int best_d;
    int d;

    // Rank each eligible input by its distance past ptr and keep the closest one.
    always_comb begin
        best   = 0;
        best_d = NUM_IN;
        d      = 0;
        found  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            d = (i + NUM_IN - 1 - int'(ptr)) % NUM_IN;
            if (elig[i] && (d < best_d)) begin
                best_d = d;
                best   = i;
                found  = 1'b1;
            end
        end
        pick = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            pick[i] = found && (i == best);
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Purpose: per-output-port round-robin arbiter over the input FIFO heads, registered output.
// Latency: 1 cycle from eligible head to valid_out; back-to-back reloads give 1 packet/cycle.
// Backpressure: output held stable while ready_out=0; no grant until the held packet is taken.
// Optional: ARB_STATS_EN adds saturating delivered/stall counters (ports read 0 otherwise).
module output_port_arbiter #(
    parameter int PORT_ID = 0,
    parameter int NUM_IN  = 4,
    parameter int DATA_W  = 8,
    parameter int TGT_W   = 4,
    localparam int SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        req_valid,
    input  logic [NUM_IN*TGT_W-1:0]  req_target,
    input  logic [NUM_IN*DATA_W-1:0] req_data,
    output logic [NUM_IN-1:0]        grant,
    output logic                     valid_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [SRC_W-1:0]         src_out,
    output logic [TGT_W-1:0]         target_out,
    input  logic                     ready_out,
    output logic [15:0]              stat_pkts,
    output logic [15:0]              stat_stalls
);

    import packet_pkg::*;

    arb_state_e          state;
    logic [SRC_W-1:0]    ptr;
    logic [NUM_IN-1:0]   elig;
    logic [NUM_IN-1:0]   pick_oh;
    logic                found;
    logic                load;
    logic [SRC_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic [TGT_W-1:0]    pick_tgt;

    // A head competes here only while its remaining mask still names this port.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            elig[i] = req_valid[i] & req_target[i*TGT_W + PORT_ID];
        end
    end

    rr_pick #(
        .NUM_IN (NUM_IN),
        .PTR_W  (SRC_W)
    ) u_rr_pick (
        .elig  (elig),
        .ptr   (ptr),
        .pick  (pick_oh),
        .found (found)
    );

    // Mux the winning head's index, payload and mask from the one-hot pick.
    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        pick_tgt  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (pick_oh[i]) begin
                pick_idx  = SRC_W'(i);
                pick_data = req_data[i*DATA_W +: DATA_W];
                pick_tgt  = req_target[i*TGT_W +: TGT_W];
            end
        end
    end

    // Load when the output slot is free or is being emptied this cycle; never during reset.
    assign load  = rst_n && found && ((state == IDLE) || (valid_out && ready_out));
    assign grant = load ? pick_oh : '0;

    // Output FSM: IDLE waits for a request, HOLD keeps the packet until the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= SRC_W'(NUM_IN - 1);
            valid_out  <= 1'b0;
            data_out   <= '0;
            src_out    <= '0;
            target_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state      <= HOLD;
                        ptr        <= pick_idx;
                        valid_out  <= 1'b1;
                        data_out   <= pick_data;
                        src_out    <= pick_idx;
                        target_out <= pick_tgt;
                    end
                end
                HOLD: begin
                    if (ready_out) begin
                        if (load) begin
                            ptr        <= pick_idx;
                            data_out   <= pick_data;
                            src_out    <= pick_idx;
                            target_out <= pick_tgt;
                        end else begin
                            state     <= IDLE;
                            valid_out <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] pkts_cnt;
    logic [15:0] stalls_cnt;

    // Saturating counters for delivered packets and sink-stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkts_cnt   <= '0;
            stalls_cnt <= '0;
        end else begin
            if (valid_out && ready_out && (pkts_cnt != 16'hFFFF)) begin
                pkts_cnt <= pkts_cnt + 16'd1;
            end
            if (valid_out && !ready_out && (stalls_cnt != 16'hFFFF)) begin
                stalls_cnt <= stalls_cnt + 16'd1;
            end
        end
    end

    assign stat_pkts   = pkts_cnt;
    assign stat_stalls = stalls_cnt;
`else
    assign stat_pkts   = 16'h0000;
    assign stat_stalls = 16'h0000;
`endif

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- One instance per switch output port, placed between the four per-port input FIFO stages and the output port interface.
- Selects one input FIFO head per cycle from the heads whose target mask includes this port, using round-robin arbitration.
- Registers the selected packet on the output, with backpressure from the sink.
- Pulses a per-input grant so that input stage can clear this port's target bit, or pop its FIFO once the mask reaches zero.

Parameters:
- PORT_ID, 0, index of the output port served; selects bit PORT_ID of each request target mask.
- NUM_IN, 4, number of input FIFO heads arbitrated.
- DATA_W, 8, payload width.
- TGT_W, 4, target mask width (one bit per output port).

Ports:
- clk  in  1  switch clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_IN  input FIFO head i is non-empty
- req_target  in  NUM_IN*TGT_W  flattened remaining target mask of each head (slice i = bits [i*TGT_W +: TGT_W])
- req_data  in  NUM_IN*DATA_W  flattened payload of each head
- grant  out  NUM_IN  one-hot, combinational; asserted in the cycle the head copy is loaded
- valid_out  out  1  output register holds a packet
- data_out  out  DATA_W  payload of the held packet
- src_out  out  $clog2(NUM_IN)  index of the input the held packet came from
- target_out  out  TGT_W  target mask of the held packet as seen at load time
- ready_out  in  1  sink accepts the packet when valid_out && ready_out
- stat_pkts  out  16  delivered-packet count (feature-gated)
- stat_stalls  out  16  stall-cycle count (feature-gated)

Behaviour:
- Reset (async, rst_n=0):
  - valid_out=0; data_out, src_out and target_out = 0; grant=0.
  - State = IDLE; rr pointer = NUM_IN-1, so input 0 has first priority after reset.
  - Reset during HOLD discards the held packet, and no grant is issued on the reset cycle.
- Eligibility: elig[i] = req_valid[i] & req_target[i][PORT_ID].
- Pick: the first elig index scanning from ptr+1, wrapping modulo NUM_IN.
- Load condition: load = (state==IDLE || (valid_out && ready_out)) && |elig.
- On load:
  - grant[pick]=1 in that cycle.
  - At the clock edge: data_out/src_out/target_out latch head pick, valid_out=1, ptr=pick, state=HOLD.
- States:
  - IDLE: valid_out=0. Goes to HOLD on load.
  - HOLD: valid_out=1, and the output holds stable while ready_out=0.
  - HOLD, on valid_out && ready_out: if load then reload back-to-back and stay in HOLD; else valid_out=0 and go to IDLE.
- Latency: a request seen in IDLE appears on valid_out the next cycle.
- Throughput: 1 packet/cycle with ready_out held high.
- Upstream contract:
  - Heads are stable until granted.
  - One cycle after grant[i], head i presents either its mask with bit PORT_ID cleared or the next FIFO entry.
  - The arbiter never grants the same head copy twice.
- Multicast: each output arbiter grants independently; no inter-port ordering is guaranteed.
- Loopback: a head whose src equals PORT_ID is eligible like any other.
- No eligible request while in HOLD: the held packet persists until accepted, and grant stays 0.
- grant is all-zero whenever load=0.

Optional Feature:
- Macro: ARB_STATS_EN.
- With the macro defined:
  - stat_pkts increments on each valid_out && ready_out.
  - stat_stalls increments on each cycle with valid_out && !ready_out.
  - Both counters are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Without the macro: both ports remain present, tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package (packet_pkg) holds:
  - NUM_PORTS=4 and TGT_W=4
  - port_idx_t (logic [1:0])
  - arb_state_e {IDLE, HOLD}
- Natural sub-module: rr_pick.
  - Combinational: inputs are the elig vector and the ptr; outputs are the one-hot pick and the found flag.
  - Parameterised on NUM_IN and reused by all four arbiters.

Test Plan:
- Reset mid-HOLD: PORT_ID=2, head 1 target=4'b0100, ready_out=0 for 3 cycles, then rst_n pulse -> valid_out drops to 0 asynchronously; after release, the first grant goes to input 0 if eligible.
- Round-robin fairness: all 4 heads target 4'b0100, ready_out=1, heads refill each grant -> grant sequence 0,1,2,3,0,... and valid_out stays high every cycle.
- Backpressure: single head 3 data=8'hA5, ready_out low for 5 cycles -> data_out=8'hA5 and src_out=3 held stable, grant pulses exactly once, stat_stalls=5 (ARB_STATS_EN).
- Non-eligible filter: head 0 target=4'b1011 with PORT_ID=2 -> grant=0 and valid_out stays 0 indefinitely.
- Back-to-back reload: heads 0 and 2 eligible, ready_out=1 -> packets from 0 then 2 on consecutive cycles with no IDLE gap; then IDLE once no head is eligible.
- Saturation: force 70000 deliveries with ARB_STATS_EN -> stat_pkts=16'hFFFF and it does not wrap.
